// File: rtl/mips_pipe_pkg.sv
// mips_pipe_pkg: shared definitions for the MIPS pipeline MEM/WB slice.
//   WB/M control-bundle bit indices, MEM-stage FSM state type and the
//   default memory-access timeout.
package mips_pipe_pkg;

  localparam int unsigned WB_REGWRITE = 1;
  localparam int unsigned WB_MEMTOREG = 0;
  localparam int unsigned M_MEMREAD   = 1;
  localparam int unsigned M_MEMWRITE  = 0;

  localparam int unsigned TIMEOUT_CYCLES_DEF = 16;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

endpackage

// File: rtl/mem_wb_stage_reg.sv
// mem_wb_reg: MEM/WB pipeline register with bubble insertion.
//   clk, reset     : clock, synchronous active-high reset
//   i_bubble       : 1 = clear RegWrite, hold data and destination
//   i_regwrite     : RegWrite to register
//   i_wdata, i_wid : writeback data and destination register
//   o_regwrite, o_wdata, o_wid : registered writeback bundle
module mem_wb_reg (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_bubble,
  input  logic        i_regwrite,
  input  logic [31:0] i_wdata,
  input  logic [4:0]  i_wid,
  output logic        o_regwrite,
  output logic [31:0] o_wdata,
  output logic [4:0]  o_wid
);

  logic        r_regwrite;
  logic [31:0] r_wdata;
  logic [4:0]  r_wid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_regwrite <= 1'b0;
      r_wdata    <= '0;
      r_wid      <= '0;
    end else if (i_bubble) begin
      r_regwrite <= 1'b0;
    end else begin
      r_regwrite <= i_regwrite;
      r_wdata    <= i_wdata;
      r_wid      <= i_wid;
    end
  end

  assign o_regwrite = r_regwrite;
  assign o_wdata    = r_wdata;
  assign o_wid      = r_wid;

endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM-stage data-memory access controller + MEM/WB register.
//   clk, reset                 : clock, synchronous active-high reset
//   WB_IN [1]RegWrite [0]MemtoReg, M_IN [1]MemRead [0]MemWrite
//   ALU_resultIN, Mem_WDataIN, Reg_WIDIN : EX/MEM bundle
//   dmem_req/we/addr/wdata (out), dmem_ack/rdata (in) : memory handshake
//   stall   : freeze front of pipeline while an access is outstanding
//   bus_err : one-cycle pulse on timeout abort (or misaligned access)
//   RegWrite_OUT, Reg_WDataOUT, Reg_WIDOUT : MEM/WB register outputs
// Optional: define MEM_ALIGN_CHECK_EN to suppress misaligned accesses.
module mem_wb_stage
  import mips_pipe_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  WB_IN,
  input  logic [1:0]  M_IN,
  input  logic [31:0] ALU_resultIN,
  input  logic [31:0] Mem_WDataIN,
  input  logic [4:0]  Reg_WIDIN,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall,
  output logic        bus_err,
  output logic        RegWrite_OUT,
  output logic [31:0] Reg_WDataOUT,
  output logic [4:0]  Reg_WIDOUT
);

  mem_state_t       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_bus_err;

  logic             w_access;
  logic             w_misalign;
  logic             w_go;
  logic             w_timeout;
  logic             w_done;
  logic             w_abort;
  logic [31:0]      w_rdata_sel;
  logic [31:0]      w_wb_data;
  logic             w_wb_regwrite;

  assign w_access = M_IN[M_MEMREAD] | M_IN[M_MEMWRITE];

`ifdef MEM_ALIGN_CHECK_EN
  assign w_misalign = w_access & (ALU_resultIN[1:0] != 2'b00);
`else
  assign w_misalign = 1'b0;
`endif

  // Only an aligned access is presented to memory.
  assign w_go = w_access & ~w_misalign;

  assign dmem_we    = M_IN[M_MEMWRITE];
  assign dmem_addr  = ALU_resultIN;
  assign dmem_wdata = Mem_WDataIN;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_bus_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bus_err <= w_abort | w_misalign;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_go && !dmem_ack) begin
          w_state_nxt = WAIT;
          w_cnt_nxt   = '0;
        end
      end
      WAIT: begin
        if (!w_go || w_done) begin
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output logic; an ack on the timeout cycle wins over the abort.
  always_comb begin
    w_timeout = (r_state == WAIT) && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    w_done    = dmem_ack | w_timeout;
    w_abort   = w_go & w_timeout & ~dmem_ack;
    dmem_req  = w_go & ~reset;
    stall     = w_go & ~w_done & ~reset;
  end

  // Aborted reads return zero.
  assign w_rdata_sel   = dmem_ack ? dmem_rdata : '0;
  assign w_wb_data     = WB_IN[WB_MEMTOREG] ? w_rdata_sel : ALU_resultIN;
  assign w_wb_regwrite = WB_IN[WB_REGWRITE] & ~w_misalign;

  assign bus_err = r_bus_err;

  mem_wb_reg u_mem_wb_reg (
    .clk        (clk),
    .reset      (reset),
    .i_bubble   (stall),
    .i_regwrite (w_wb_regwrite),
    .i_wdata    (w_wb_data),
    .i_wid      (Reg_WIDIN),
    .o_regwrite (RegWrite_OUT),
    .o_wdata    (Reg_WDataOUT),
    .o_wid      (Reg_WIDOUT)
  );

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed bench for mem_wb_stage with a cycle model
// (counts wait cycles of the current access) checked every cycle, plus
// hand-computed expectations at key points of each scenario.
module tb_mem_wb_stage;

  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  WB_IN, M_IN;
  logic [31:0] ALU_resultIN, Mem_WDataIN, dmem_rdata;
  logic [4:0]  Reg_WIDIN;
  logic        dmem_ack;
  logic        dmem_req, dmem_we, stall, bus_err, RegWrite_OUT;
  logic [31:0] dmem_addr, dmem_wdata, Reg_WDataOUT;
  logic [4:0]  Reg_WIDOUT;

  mem_wb_stage #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .WB_IN        (WB_IN),
    .M_IN         (M_IN),
    .ALU_resultIN (ALU_resultIN),
    .Mem_WDataIN  (Mem_WDataIN),
    .Reg_WIDIN    (Reg_WIDIN),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_ack     (dmem_ack),
    .dmem_rdata   (dmem_rdata),
    .stall        (stall),
    .bus_err      (bus_err),
    .RegWrite_OUT (RegWrite_OUT),
    .Reg_WDataOUT (Reg_WDataOUT),
    .Reg_WIDOUT   (Reg_WIDOUT)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  bit run   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  int          m_wait;   // stalled request cycles spent on the current access
  logic        m_rw;
  logic [31:0] m_wd;
  logic [4:0]  m_wid;
  logic        m_berr;

  function automatic logic m_misal();
`ifdef MEM_ALIGN_CHECK_EN
    return (M_IN != 2'b00) && (ALU_resultIN[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic m_req();
    return (M_IN != 2'b00) && !m_misal() && !reset;
  endfunction

  // An access gives up once it has stalled TO cycles without an ack.
  function automatic logic m_stall();
    return m_req() && !dmem_ack && (m_wait != TO);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_wait = 0; m_rw = 1'b0; m_wd = '0; m_wid = '0; m_berr = 1'b0;
    end else begin
      m_berr = m_misal() || (m_req() && !dmem_ack && m_wait == TO);
      if (m_stall()) begin
        m_wait++;
        m_rw = 1'b0;
      end else begin
        m_wait = 0;
        m_rw   = WB_IN[1] && !m_misal();
        m_wid  = Reg_WIDIN;
        m_wd   = WB_IN[0] ? (dmem_ack ? dmem_rdata : 32'h0) : ALU_resultIN;
      end
    end
  end

  always @(negedge clk) begin
    if (run) begin
      chk("dmem_req",     dmem_req,     m_req());
      chk("stall",        stall,        m_stall());
      chk("dmem_we",      dmem_we,      M_IN[0]);
      chk("dmem_addr",    dmem_addr,    ALU_resultIN);
      chk("dmem_wdata",   dmem_wdata,   Mem_WDataIN);
      chk("RegWrite_OUT", RegWrite_OUT, m_rw);
      chk("Reg_WDataOUT", Reg_WDataOUT, m_wd);
      chk("Reg_WIDOUT",   Reg_WIDOUT,   m_wid);
      chk("bus_err",      bus_err,      m_berr);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic rst, input logic [1:0] m, input logic [1:0] wb,
                      input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] wid,
                      input logic ack, input logic [31:0] rd);
    @(posedge clk);
    #1;
    reset = rst; M_IN = m; WB_IN = wb; ALU_resultIN = alu; Mem_WDataIN = wd;
    Reg_WIDIN = wid; dmem_ack = ack; dmem_rdata = rd;
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err + 1);
    $fatal(1);
  end

  initial begin
    int  nst;
    bit  fin;
    reset = 1'b1; M_IN = 2'b10; WB_IN = 2'b11; ALU_resultIN = 32'h100;
    Mem_WDataIN = '0; Reg_WIDIN = 5'd1; dmem_ack = 1'b0; dmem_rdata = '0;

    // reset with a pending access: nothing requested, outputs cleared
    step(1'b1, 2'b10, 2'b11, 32'h100, 32'h0, 5'd1, 1'b0, 32'h0);
    run = 1'b1;
    step(1'b1, 2'b10, 2'b11, 32'h100, 32'h0, 5'd1, 1'b0, 32'h0);
    chk("rst_req", dmem_req, 1'b0);
    chk("rst_stall", stall, 1'b0);
    chk("rst_regwrite", RegWrite_OUT, 1'b0);
    chk("rst_wdata", Reg_WDataOUT, 32'h0);

    // zero-wait load
    step(1'b0, 2'b10, 2'b11, 32'h100, 32'h0, 5'd2, 1'b1, 32'hCAFEF00D);
    chk("zw_stall", stall, 1'b0);
    chk("zw_req", dmem_req, 1'b1);
    idle();
    chk("zw_regwrite", RegWrite_OUT, 1'b1);
    chk("zw_wdata", Reg_WDataOUT, 32'hCAFEF00D);
    chk("zw_wid", Reg_WIDOUT, 5'd2);

    // load with 3 wait cycles
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 2'b10, 2'b11, 32'h200, 32'h0, 5'd7, 1'b0, 32'h0);
      chk("w3_stall", stall, 1'b1);
      chk("w3_req", dmem_req, 1'b1);
      chk("w3_regwrite_bubble", RegWrite_OUT, 1'b0);
    end
    step(1'b0, 2'b10, 2'b11, 32'h200, 32'h0, 5'd7, 1'b1, 32'h12345678);
    chk("w3_ack_stall", stall, 1'b0);
    chk("w3_ack_req", dmem_req, 1'b1);
    idle();
    chk("w3_regwrite", RegWrite_OUT, 1'b1);
    chk("w3_wdata", Reg_WDataOUT, 32'h12345678);
    chk("w3_wid", Reg_WIDOUT, 5'd7);

    // store (1 wait) then ALU op
    step(1'b0, 2'b01, 2'b00, 32'h300, 32'hDEADBEEF, 5'd0, 1'b0, 32'h0);
    chk("st_we", dmem_we, 1'b1);
    chk("st_stall", stall, 1'b1);
    chk("st_addr", dmem_addr, 32'h300);
    chk("st_wdata", dmem_wdata, 32'hDEADBEEF);
    step(1'b0, 2'b01, 2'b00, 32'h300, 32'hDEADBEEF, 5'd0, 1'b1, 32'h0);
    chk("st_ack_stall", stall, 1'b0);
    step(1'b0, 2'b00, 2'b10, 32'h55, 32'h0, 5'd3, 1'b0, 32'h0);
    chk("st_regwrite", RegWrite_OUT, 1'b0);
    idle();
    chk("alu_regwrite", RegWrite_OUT, 1'b1);
    chk("alu_wdata", Reg_WDataOUT, 32'h55);
    chk("alu_wid", Reg_WIDOUT, 5'd3);

    // timeout: read never acknowledged
    nst = 0;
    fin = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 2'b10, 2'b11, 32'h400, 32'h0, 5'd9, 1'b0, 32'h0);
      if (stall) nst++;
      else begin
        fin = 1'b1;
        break;
      end
    end
    chk("to_released", fin, 1'b1);
    chk("to_stall_cycles", nst, TO);
    chk("to_no_err_yet", bus_err, 1'b0);
    idle();
    chk("to_bus_err", bus_err, 1'b1);
    chk("to_wdata_zero", Reg_WDataOUT, 32'h0);
    chk("to_regwrite", RegWrite_OUT, 1'b1);
    chk("to_wid", Reg_WIDOUT, 5'd9);
    idle();
    chk("to_bus_err_pulse", bus_err, 1'b0);

    // reset in the middle of a wait
    step(1'b0, 2'b10, 2'b11, 32'h500, 32'h0, 5'd5, 1'b0, 32'h0);
    step(1'b0, 2'b10, 2'b11, 32'h500, 32'h0, 5'd5, 1'b0, 32'h0);
    chk("rw_stall_before", stall, 1'b1);
    step(1'b1, 2'b10, 2'b11, 32'h500, 32'h0, 5'd5, 1'b0, 32'h0);
    chk("rw_req", dmem_req, 1'b0);
    chk("rw_stall", stall, 1'b0);
    step(1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 5'd0, 1'b1, 32'hFFFF0000);
    chk("rw_regwrite", RegWrite_OUT, 1'b0);
    chk("rw_wdata", Reg_WDataOUT, 32'h0);
    chk("rw_wid", Reg_WIDOUT, 5'd0);
    chk("rw_bus_err", bus_err, 1'b0);
    chk("rw_stray_ack_stall", stall, 1'b0);
    idle();
    chk("rw_bus_err2", bus_err, 1'b0);
    chk("rw_regwrite2", RegWrite_OUT, 1'b0);

    // misaligned load
`ifdef MEM_ALIGN_CHECK_EN
    step(1'b0, 2'b10, 2'b11, 32'h102, 32'h0, 5'd4, 1'b0, 32'h0);
    chk("al_req", dmem_req, 1'b0);
    chk("al_stall", stall, 1'b0);
    idle();
    chk("al_bus_err", bus_err, 1'b1);
    chk("al_regwrite", RegWrite_OUT, 1'b0);
`else
    step(1'b0, 2'b10, 2'b11, 32'h102, 32'h0, 5'd4, 1'b1, 32'hA5A5A5A5);
    chk("al_addr", dmem_addr, 32'h102);
    chk("al_req", dmem_req, 1'b1);
    idle();
    chk("al_wdata", Reg_WDataOUT, 32'hA5A5A5A5);
    chk("al_bus_err", bus_err, 1'b0);
`endif

    idle();
    idle();
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
